// File: rtl/spi_receptor.sv
// SPI slave receiver: oversamples SCK/SS/MOSI on CLK, supports all four
// CKP/CPH modes, shifts a WIDTH-bit word in on MOSI while returning TX_DATA
// on MISO MSB first, and flags each received word with a one-cycle pulse.
module spi_receptor #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             SCK,
    input  logic             SS,
    input  logic             MOSI,
    input  logic [WIDTH-1:0] TX_DATA,
    output logic             MISO,
    output logic             MISO_OE,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_d_r;
    logic                   ss_d_r;

    logic                   sck_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   leading_s;
    logic                   trailing_s;
    logic                   sample_s;
    logic                   shift_s;
    logic                   ss_fall_s;

    state_t                 state_r,    state_nxt_s;
    logic [WIDTH-1:0]       tx_shift_r, tx_shift_nxt_s;
    logic [WIDTH-1:0]       rx_shift_r, rx_shift_nxt_s;
    logic [CNT_W-1:0]       bit_cnt_r,  bit_cnt_nxt_s;
    logic [WIDTH-1:0]       rx_data_r,  rx_data_nxt_s;
    logic                   rx_valid_r, rx_valid_nxt_s;
    logic                   busy_r,     busy_nxt_s;
    logic                   miso_r,     miso_nxt_s;
    logic                   miso_oe_r,  miso_oe_nxt_s;

    // Synchronizer chains; SCK stages start at the idle level and SS starts
    // deselected so that releasing reset never looks like an edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sck_sync_r  <= {SYNC_STAGES{CKP}};
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_d_r     <= CKP;
            ss_d_r      <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], SS};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
            sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
            ss_d_r      <= ss_sync_r[SYNC_STAGES-1];
        end
    end

    // MOSI comes from the same stage as SCK so data and edge stay aligned.
    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign ss_s       = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign leading_s  = (sck_d_r == CKP) && (sck_s != CKP);
    assign trailing_s = (sck_d_r != CKP) && (sck_s == CKP);
    assign sample_s   = CPH ? trailing_s : leading_s;
    assign shift_s    = CPH ? leading_s  : trailing_s;
    assign ss_fall_s  = ss_d_r & ~ss_s;

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            tx_shift_r <= {WIDTH{1'b0}};
            rx_shift_r <= {WIDTH{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            rx_data_r  <= {WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_valid_r <= rx_valid_nxt_s;
            busy_r     <= busy_nxt_s;
            miso_r     <= miso_nxt_s;
            miso_oe_r  <= miso_oe_nxt_s;
        end
    end

    // Next-state and next-output logic. A shift edge with the counter at
    // zero never advances the word: for CPH=1 it only presents the MSB, for
    // CPH=0 it is the leftover trailing edge of the previous frame.
    always_comb begin
        state_nxt_s    = state_r;
        tx_shift_nxt_s = tx_shift_r;
        rx_shift_nxt_s = rx_shift_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        rx_data_nxt_s  = rx_data_r;
        rx_valid_nxt_s = 1'b0;
        busy_nxt_s     = busy_r;
        miso_nxt_s     = miso_r;
        miso_oe_nxt_s  = miso_oe_r;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_nxt_s    = ST_SHIFT;
                    tx_shift_nxt_s = TX_DATA;
                    bit_cnt_nxt_s  = {CNT_W{1'b0}};
                    busy_nxt_s     = 1'b1;
                    miso_oe_nxt_s  = 1'b1;
                    miso_nxt_s     = CPH ? 1'b0 : TX_DATA[WIDTH-1];
                end else begin
                    busy_nxt_s     = 1'b0;
                    miso_oe_nxt_s  = 1'b0;
                    miso_nxt_s     = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (ss_s) begin
                    state_nxt_s    = ST_IDLE;
                    bit_cnt_nxt_s  = {CNT_W{1'b0}};
                    busy_nxt_s     = 1'b0;
                    miso_oe_nxt_s  = 1'b0;
                    miso_nxt_s     = 1'b0;
                end else if (sample_s) begin
                    rx_shift_nxt_s = {rx_shift_r[WIDTH-2:0], mosi_s};
                    bit_cnt_nxt_s  = bit_cnt_r + CNT_W'(1);
                    if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_nxt_s    = ST_DONE;
                        rx_data_nxt_s  = {rx_shift_r[WIDTH-2:0], mosi_s};
                        rx_valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s    = ST_SHIFT;
                    end
                end else if (shift_s) begin
                    if (bit_cnt_r != {CNT_W{1'b0}}) begin
                        tx_shift_nxt_s = {tx_shift_r[WIDTH-2:0], 1'b0};
                        miso_nxt_s     = tx_shift_r[WIDTH-2];
                    end else if (CPH) begin
                        miso_nxt_s     = tx_shift_r[WIDTH-1];
                    end else begin
                        miso_nxt_s     = miso_r;
                    end
                end else begin
                    state_nxt_s    = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (!ss_s) begin
                    state_nxt_s    = ST_SHIFT;
                    tx_shift_nxt_s = TX_DATA;
                    bit_cnt_nxt_s  = {CNT_W{1'b0}};
                    miso_nxt_s     = CPH ? miso_r : TX_DATA[WIDTH-1];
                end else begin
                    state_nxt_s    = ST_IDLE;
                    bit_cnt_nxt_s  = {CNT_W{1'b0}};
                    busy_nxt_s     = 1'b0;
                    miso_oe_nxt_s  = 1'b0;
                    miso_nxt_s     = 1'b0;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                bit_cnt_nxt_s  = {CNT_W{1'b0}};
                busy_nxt_s     = 1'b0;
                miso_oe_nxt_s  = 1'b0;
                miso_nxt_s     = 1'b0;
            end
        endcase
    end

    assign MISO     = miso_r;
    assign MISO_OE  = miso_oe_r;
    assign RX_DATA  = rx_data_r;
    assign RX_VALID = rx_valid_r;
    assign BUSY     = busy_r;

endmodule
